// File: rtl/mem_sum_pkg.sv
// mem_sum_pkg: shared types and default widths for the mem_sum_engine slice.
//   sum_state_t : engine FSM states (S_WRITE is only reachable when the
//                 SUM_WRITEBACK_EN macro is defined)
//   *_DEF       : default data/address/count widths
package mem_sum_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } sum_state_t;

endpackage

// File: rtl/mem_sum_engine_if.sv
// mem_sum_engine_if: memory-side bus between the summing engine and the data
// memory.
//   mem_addr  : word address
//   mem_read  : read enable
//   mem_write : write enable
//   mem_wdata : write data
//   mem_rdata : read data, combinational from the memory for mem_addr
// Modports: master (engine side), slave (memory side).
interface mem_sum_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_sum_engine_sum_acc.sv
// sum_acc: running-sum register with sticky carry-out.
//   clk, rst : clock, synchronous active-low reset
//   clr      : zero sum and overflow (wins over en)
//   en       : add din into the sum this edge
//   din      : addend
//   sum      : registered running sum, modulo 2^DATA_W
//   overflow : sticky, set by any carry-out since the last clear
module sum_acc #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum,
    output logic              overflow
);
    // One extra bit on the adder to capture the carry-out.
    logic [DATA_W:0] add;

    assign add = {1'b0, sum} + {1'b0, din};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            sum      <= '0;
            overflow <= 1'b0;
        end else if (en) begin
            sum      <= add[DATA_W-1:0];
            overflow <= overflow | add[DATA_W];
        end
    end
endmodule

// File: rtl/mem_sum_engine.sv
// mem_sum_engine: reads `count` consecutive words from base_addr, one per
// clock, and returns their sum with a one-cycle done pulse.
//   clk, rst  : clock, synchronous active-low reset
//   start     : run request, only looked at while idle
//   base_addr : first word address (latched on accepted start)
//   count     : number of words (latched on accepted start)
//   busy      : high outside IDLE
//   done      : one-cycle completion pulse
//   sum       : result, held until the next accepted start
//   overflow  : sticky carry-out of the accumulation
//   mem       : memory bus (master side)
// Optional feature macro SUM_WRITEBACK_EN: after the last read, write the sum
// to RESULT_ADDR for one cycle before signalling done. Without it mem_write
// and mem_wdata are held at 0.
module mem_sum_engine
    import mem_sum_pkg::*;
#(
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                CNT_W       = CNT_W_DEF,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = ADDR_W'(1010)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     count,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    sum,
    output logic                 overflow,
    mem_sum_engine_if.master     mem
);
    sum_state_t        state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  idx;
    logic              acc_clr, acc_en, last_rd, accept;

    assign accept  = (state == S_IDLE) && start;
    // READ is only entered with cnt_q != 0, so cnt_q-1 never underflows there.
    assign last_rd = (idx == cnt_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q <= '0;
            cnt_q  <= '0;
            idx    <= '0;
        end else if (accept) begin
            base_q <= base_addr;
            cnt_q  <= count;
            idx    <= '0;
        end else if (state == S_READ) begin
            idx <= idx + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_clr  = 1'b1;
                    state_nx = (count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                acc_en = 1'b1;
                if (last_rd) begin
`ifdef SUM_WRITEBACK_EN
                    state_nx = S_WRITE;
`else
                    state_nx = S_DONE;
`endif
                end
            end
`ifdef SUM_WRITEBACK_EN
            S_WRITE: state_nx = S_DONE;
`endif
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    sum_acc #(.DATA_W(DATA_W)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .en       (acc_en),
        .din      (mem.mem_rdata),
        .sum      (sum),
        .overflow (overflow)
    );

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Bus outputs decode state and registers only; the read address wraps
    // naturally at 2^ADDR_W.
    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_wdata = '0;
        if (state == S_READ) begin
            mem.mem_addr = base_q + ADDR_W'(idx);
            mem.mem_read = 1'b1;
        end
`ifdef SUM_WRITEBACK_EN
        if (state == S_WRITE) begin
            mem.mem_addr  = RESULT_ADDR;
            mem.mem_write = 1'b1;
            mem.mem_wdata = sum;
        end
`endif
    end
endmodule

// File: tb/tb_mem_sum_engine.sv
module tb_mem_sum_engine;
    import mem_sum_pkg::*;

`ifdef SUM_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [7:0]  count = '0;
    logic        busy, done, overflow;
    logic [31:0] sum;

    mem_sum_engine_if #(.ADDR_W(32), .DATA_W(32)) mbus ();

    mem_sum_engine #(.DATA_W(32), .ADDR_W(32), .CNT_W(8), .RESULT_ADDR(32'd1010)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .overflow  (overflow),
        .mem       (mbus)
    );

    always #5 clk = ~clk;

    // Memory model: 2K words, indexed by the low address bits.
    logic [31:0] mem_arr [0:2047];
    assign mbus.mem_rdata = mem_arr[mbus.mem_addr[10:0]];
    always @(posedge clk) if (mbus.mem_write) mem_arr[mbus.mem_addr[10:0]] <= mbus.mem_wdata;

    typedef struct { logic [31:0] s; logic o; } exp_t;
    exp_t sb[$];

    typedef struct {
        string       nm;
        logic [31:0] b;
        logic [7:0]  n;
        logic [31:0] es;
        logic        eo;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_one(input vec_t v);
        int reads, writes, bad, cyc, lat, wexp;
        bit seen;
        exp_t e;
        @(negedge clk);
        start = 1'b1; base_addr = v.b; count = v.n;
        sb.push_back('{s: v.es, o: v.eo});
        @(negedge clk);  // edge k has passed; now in cycle k+1
        start = 1'b0;
        reads = 0; writes = 0; bad = 0; seen = 0; lat = 0; cyc = 1;
        while (!seen && cyc <= 300) begin
            if (mbus.mem_read) begin
                reads++;
                if (mbus.mem_addr !== v.b + 32'(cyc - 1)) bad++;
            end
            if (mbus.mem_write) writes++;
            if (mbus.mem_read && mbus.mem_write) bad++;
            if (done) begin
                seen = 1; lat = cyc;
                e = sb.pop_front();
                chk({v.nm, " sum"}, 64'(sum), 64'(e.s));
                chk({v.nm, " overflow"}, 64'(overflow), 64'(e.o));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        wexp = (v.n != 0) ? WB : 0;
        chk({v.nm, " done seen"}, 64'(seen), 64'd1);
        chk({v.nm, " latency"}, 64'(lat), 64'(int'(v.n) + 1 + wexp));
        chk({v.nm, " reads"}, 64'(reads), 64'(v.n));
        chk({v.nm, " writes"}, 64'(writes), 64'(wexp));
        chk({v.nm, " addr/bus errs"}, 64'(bad), 64'd0);
        @(negedge clk);
        chk({v.nm, " done pulse width"}, 64'(done), 64'd0);
        chk({v.nm, " busy after"}, 64'(busy), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int dcnt, bound;
        for (int a = 0; a < 2048; a++) mem_arr[a] = '0;
        for (int a = 0; a < 10; a++) mem_arr[1000 + a] = 32'(a + 1);
        mem_arr[200] = 32'hFFFF_FFFF; mem_arr[201] = 32'd2; mem_arr[202] = 32'd3;
        mem_arr[2047] = 32'd5; mem_arr[0] = 32'd7;

        vecs[0] = '{nm: "sum10",   b: 32'd1000,      n: 8'd10, es: 32'd55, eo: 1'b0};
        vecs[1] = '{nm: "cnt0",    b: 32'd1000,      n: 8'd0,  es: 32'd0,  eo: 1'b0};
        vecs[2] = '{nm: "ovf2",    b: 32'd200,       n: 8'd2,  es: 32'd1,  eo: 1'b1};
        vecs[3] = '{nm: "ovf3",    b: 32'd200,       n: 8'd3,  es: 32'd4,  eo: 1'b1};
        vecs[4] = '{nm: "mid3",    b: 32'd1005,      n: 8'd3,  es: 32'd21, eo: 1'b0};
        vecs[5] = '{nm: "wrap2",   b: 32'hFFFF_FFFF, n: 8'd2,  es: 32'd12, eo: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst sum", 64'(sum), 64'd0);
        chk("rst overflow", 64'(overflow), 64'd0);
        chk("rst mem_read", 64'(mbus.mem_read), 64'd0);
        chk("rst mem_write", 64'(mbus.mem_write), 64'd0);
        chk("rst mem_addr", 64'(mbus.mem_addr), 64'd0);
        rst = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_one(vecs[k]);
`ifdef SUM_WRITEBACK_EN
            if (k == 0) chk("writeback mem[1010]", 64'(mem_arr[1010]), 64'd55);
`endif
        end
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        // start held high: one done per run, restart only from IDLE
        @(negedge clk);
        start = 1'b1; base_addr = 32'd1009; count = 8'd1;
        @(negedge clk);
        chk("hold busy", 64'(busy), 64'd1);
        dcnt = 0;
        for (int c = 1; c <= 2 + WB; c++) begin
            if (done) dcnt++;
            if (c < 2 + WB) @(negedge clk);
        end
        chk("hold done at end", 64'(done), 64'd1);
        chk("hold one done", 64'(dcnt), 64'd1);
        chk("hold sum", 64'(sum), 64'd10);
        @(negedge clk);
        chk("hold idle gap", 64'(busy), 64'd0);
        @(negedge clk);
        chk("hold restart", 64'(busy), 64'd1);
        start = 1'b0;
        bound = 0;
        while (!done && bound < 50) begin @(negedge clk); bound++; end
        chk("hold second done", 64'(done), 64'd1);
        chk("hold second sum", 64'(sum), 64'd10);
        @(negedge clk);

        // Reset mid-run at i=4
        @(negedge clk);
        start = 1'b1; base_addr = 32'd1000; count = 8'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort pre busy", 64'(busy), 64'd1);
        chk("abort pre addr", 64'(mbus.mem_addr), 64'd1004);
        chk("abort pre sum", 64'(sum), 64'd10);
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort mem_read", 64'(mbus.mem_read), 64'd0);
        chk("abort sum", 64'(sum), 64'd0);
        chk("abort overflow", 64'(overflow), 64'd0);
        rst = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        chk("abort no done", 64'(dcnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
